// File: rtl/vco_pkg.sv
// Shared definitions for the VCO feedback divider.
// Contents: state enum, default widths, and the minimum legal divide ratio.
package vco_pkg;

  localparam int unsigned DivWDefault = 8;
  localparam int unsigned CntWDefault = 16;
  // Smallest ratio that yields a divided clock with both a high and a low phase.
  localparam int unsigned MinRatio    = 2;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StPend = 2'd2
  } state_e;

endpackage

// File: rtl/vco_div_counter.sv
// Modulo-N cycle counter with terminal detect and registered duty/tick decode.
// Ports:
//   clk, rst     VCO clock, asynchronous active-high reset
//   count_en     divider is counting this cycle (RUN or PEND)
//   next_active  divider will be counting next cycle
//   ratio        ratio governing the current period
//   next_ratio   ratio governing the cycle after this edge
//   terminal     current cycle is the last of the period (cnt == ratio-1)
//   div_clk      registered divided clock
//   div_tick     registered one-cycle pulse in the last cycle of each period
module vco_div_counter #(
  parameter int unsigned DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             count_en,
  input  logic             next_active,
  input  logic [DIV_W-1:0] ratio,
  input  logic [DIV_W-1:0] next_ratio,
  output logic             terminal,
  output logic             div_clk,
  output logic             div_tick
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W:0]   half_ceil;
  logic             div_clk_q, div_clk_d;
  logic             div_tick_q, div_tick_d;

  assign terminal = count_en && (cnt_q == ratio - DIV_W'(1));

  always_comb begin
    cnt_d = '0;
    if (count_en && !terminal) begin
      cnt_d = cnt_q + DIV_W'(1);
    end
    // One extra bit so ceil(N/2) of the largest ratio does not overflow.
    half_ceil  = ({1'b0, next_ratio} + (DIV_W + 1)'(1)) >> 1;
    // Outputs decode the post-edge count so they can be flops without lagging cnt.
    div_clk_d  = next_active && ({1'b0, cnt_d} < half_ceil);
    div_tick_d = next_active && (cnt_d == next_ratio - DIV_W'(1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      div_clk_q  <= 1'b0;
      div_tick_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      div_clk_q  <= div_clk_d;
      div_tick_q <= div_tick_d;
    end
  end

  assign div_clk  = div_clk_q;
  assign div_tick = div_tick_q;

endmodule

// File: rtl/vco_fb_divider.sv
// Programmable integer feedback divider running on the VCO clock.
// Ratio updates arrive over a valid/ready handshake and take effect only at a
// period boundary, so every divided period is exactly N VCO cycles.
// Optional feature: define VCO_DIV_PERIOD_CNT_EN to count completed periods
// on period_cnt; otherwise period_cnt is tied to 0.
// Ports:
//   clk, rst     VCO clock, asynchronous active-high reset
//   div_n        requested ratio (0 = stop, 1 = illegal -> clamped to 2)
//   div_n_vld    div_n valid
//   div_n_rdy    ratio can be accepted this cycle (low while a change is staged)
//   div_clk      divided clock
//   div_tick     pulse in last VCO cycle of each divided period
//   running      divider is counting
//   err          sticky: a ratio of 1 was received
//   period_cnt   completed divided periods
module vco_fb_divider
  import vco_pkg::*;
#(
  parameter int unsigned DIV_W = DivWDefault,
  parameter int unsigned CNT_W = CntWDefault
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIV_W-1:0] div_n,
  input  logic             div_n_vld,
  output logic             div_n_rdy,
  output logic             div_clk,
  output logic             div_tick,
  output logic             running,
  output logic             err,
  output logic [CNT_W-1:0] period_cnt
);

  state_e           state_q, state_d;
  logic [DIV_W-1:0] ratio_q, ratio_d;
  logic [DIV_W-1:0] staged_q, staged_d;
  logic             err_q, err_d;
  logic             running_q;
  logic             xfer;
  logic             terminal;
  logic [DIV_W-1:0] n_eff;

  assign div_n_rdy = (state_q != StPend);
  assign xfer      = div_n_vld && div_n_rdy;
  assign n_eff     = (div_n == DIV_W'(1)) ? DIV_W'(MinRatio) : div_n;

  always_comb begin
    state_d  = state_q;
    ratio_d  = ratio_q;
    staged_d = staged_q;
    err_d    = err_q || (xfer && (div_n == DIV_W'(1)));
    unique case (state_q)
      StIdle: begin
        if (xfer && (n_eff != '0)) begin
          state_d = StRun;
          ratio_d = n_eff;
        end
      end
      StRun: begin
        if (xfer) begin
          if (!terminal) begin
            state_d  = StPend;
            staged_d = n_eff;
          end else if (n_eff == '0) begin
            state_d = StIdle;
          end else begin
            // Arrived in the last cycle: the wrap edge is also the apply edge.
            ratio_d = n_eff;
          end
        end
      end
      StPend: begin
        if (terminal) begin
          if (staged_q == '0) begin
            state_d = StIdle;
          end else begin
            state_d = StRun;
            ratio_d = staged_q;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      ratio_q   <= DIV_W'(MinRatio);
      staged_q  <= '0;
      err_q     <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ratio_q   <= ratio_d;
      staged_q  <= staged_d;
      err_q     <= err_d;
      running_q <= (state_d != StIdle);
    end
  end

  vco_div_counter #(
    .DIV_W (DIV_W)
  ) u_counter (
    .clk         (clk),
    .rst         (rst),
    .count_en    (state_q != StIdle),
    .next_active (state_d != StIdle),
    .ratio       (ratio_q),
    .next_ratio  (ratio_d),
    .terminal    (terminal),
    .div_clk     (div_clk),
    .div_tick    (div_tick)
  );

  assign running = running_q;
  assign err     = err_q;

`ifdef VCO_DIV_PERIOD_CNT_EN
  logic [CNT_W-1:0] period_cnt_q;

  // terminal is only raised while counting, so IDLE holds the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      period_cnt_q <= '0;
    end else if (terminal) begin
      period_cnt_q <= period_cnt_q + CNT_W'(1);
    end
  end

  assign period_cnt = period_cnt_q;
`else
  assign period_cnt = '0;
`endif

endmodule

// File: tb/tb_vco_fb_divider.sv
module tb_vco_fb_divider;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  div_n = 8'd0;
  logic        div_n_vld = 1'b0;
  logic        div_n_rdy;
  logic        div_clk;
  logic        div_tick;
  logic        running;
  logic        err;
  logic [15:0] period_cnt;

  vco_fb_divider #(
    .DIV_W (8),
    .CNT_W (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .div_n      (div_n),
    .div_n_vld  (div_n_vld),
    .div_n_rdy  (div_n_rdy),
    .div_clk    (div_clk),
    .div_tick   (div_tick),
    .running    (running),
    .err        (err),
    .period_cnt (period_cnt)
  );

  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Behavioural model: position within the current divided period.
  bit m_run, m_pend, m_err;
  int m_n, m_pos, m_staged, m_periods;
  int cyc, last_tick;
  bit last_valid;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
  endtask

  function automatic void model_reset();
    m_run = 0; m_pend = 0; m_err = 0;
    m_n = 2; m_pos = 0; m_staged = 0; m_periods = 0;
    last_valid = 0;
  endfunction

  function automatic void model_update(bit v, int n);
    bit xfer = v && !m_pend;
    int ne = (n == 1) ? 2 : n;
    if (xfer && n == 1) m_err = 1;
    if (!m_run) begin
      if (xfer && ne != 0) begin
        m_run = 1; m_n = ne; m_pos = 0;
      end
    end else if (m_pos == m_n - 1) begin
      m_periods++;
      m_pos = 0;
      if (m_pend) begin
        m_pend = 0;
        if (m_staged == 0) m_run = 0;
        else m_n = m_staged;
      end else if (xfer) begin
        if (ne == 0) m_run = 0;
        else m_n = ne;
      end
    end else begin
      m_pos++;
      if (xfer) begin
        m_pend = 1; m_staged = ne;
      end
    end
  endfunction

  task automatic compare_all();
    int exp_pc;
`ifdef VCO_DIV_PERIOD_CNT_EN
    exp_pc = m_periods % 65536;
`else
    exp_pc = 0;
`endif
    chk("div_clk", div_clk, (m_run && (m_pos < (m_n + 1) / 2)) ? 1 : 0);
    chk("div_tick", div_tick, (m_run && (m_pos == m_n - 1)) ? 1 : 0);
    chk("running", running, m_run);
    chk("err", err, m_err);
    chk("div_n_rdy", div_n_rdy, m_pend ? 0 : 1);
    chk("period_cnt", period_cnt, exp_pc);
    // Independent period-length check from observed tick spacing.
    if (div_tick === 1'b1) begin
      if (last_valid) chk("period_len", cyc - last_tick, m_n);
      last_tick  = cyc;
      last_valid = 1;
    end
    if (!m_run) last_valid = 0;
  endtask

  task automatic step();
    bit v = div_n_vld;
    int n = int'(div_n);
    @(posedge clk);
    cyc++;
    model_update(v, n);
    #1;
    compare_all();
  endtask

  task automatic load(input int n);
    div_n = n[7:0];
    div_n_vld = 1'b1;
    step();
    div_n_vld = 1'b0;
  endtask

  function automatic bit cond(input int mode, input int p);
    case (mode)
      0:       return m_run && (m_pos == p);
      1:       return m_run && (m_pos == m_n - 1);
      default: return !m_run;
    endcase
  endfunction

  // mode 0: reach position p; 1: reach terminal cycle; 2: reach idle.
  task automatic run_until(input int mode, input int p);
    int g = 0;
    while (!cond(mode, p) && g < 600) begin
      step();
      g++;
    end
    if (!cond(mode, p)) begin
      total_cnt++;
      $display("FAIL wait_mode%0d: actual=timeout required=condition within 600 cycles", mode);
    end
  endtask

  // Captures k samples of div_clk/div_tick, starting with the current cycle.
  task automatic record(input int k, output logic [7:0] cv, output logic [7:0] tv);
    cv = {7'd0, div_clk};
    tv = {7'd0, div_tick};
    for (int i = 1; i < k; i++) begin
      step();
      cv = {cv[6:0], div_clk};
      tv = {tv[6:0], div_tick};
    end
  endtask

  task automatic do_reset();
    #1;
    rst = 1'b1;
    #1;
    chk("rst_div_clk", div_clk, 0);
    chk("rst_div_tick", div_tick, 0);
    chk("rst_running", running, 0);
    chk("rst_err", err, 0);
    chk("rst_rdy", div_n_rdy, 1);
    chk("rst_period_cnt", period_cnt, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  logic [7:0] cv, tv;
  int exp_pc10;

  initial begin
    cyc = 0;
    last_tick = 0;
    model_reset();
    #12;
    chk("init_div_clk", div_clk, 0);
    chk("init_rdy", div_n_rdy, 1);
    chk("init_running", running, 0);
    compare_all();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) step();

    // N=4: 1,1,0,0 repeating, tick on the 4th cycle.
    load(4);
    record(8, cv, tv);
    chk("n4_clk_pattern", cv, 8'b1100_1100);
    chk("n4_tick_pattern", tv, 8'b0001_0001);

    // Change to 6 mid-period: staged until the wrap.
    run_until(0, 1);
    load(6);
    chk("n6_staged_rdy", div_n_rdy, 0);
    run_until(0, 5);
    chk("n6_applied_tick", div_tick, 1);

    // Change to 3 in the terminal cycle: applied at that wrap, rdy stays high.
    run_until(1, 0);
    load(3);
    chk("n3_rdy_high", div_n_rdy, 1);
    record(3, cv, tv);
    chk("n3_clk_pattern", cv, 8'b0000_0110);

    // N=5: high three, low two.
    run_until(1, 0);
    load(5);
    record(5, cv, tv);
    chk("n5_clk_pattern", cv, 8'b0001_1100);
    chk("n5_tick_pattern", tv, 8'b0000_0001);

    // N=1 behaves as 2 and sets err; then stop.
    run_until(1, 0);
    load(1);
    record(4, cv, tv);
    chk("n1_clk_pattern", cv, 8'b0000_1010);
    chk("n1_err_sticky", err, 1);
    load(0);
    run_until(2, 0);
    chk("stop_div_clk", div_clk, 0);
    chk("stop_running", running, 0);
    repeat (3) step();

    // Randomised ratio requests.
    for (int i = 0; i < 400; i++) begin
      int r = $urandom_range(0, 19);
      div_n_vld = ($urandom_range(0, 3) == 0);
      div_n = (r == 18) ? 8'd255 : (r == 19) ? 8'd254 : r[7:0];
      step();
    end
    div_n_vld = 1'b0;

    // Ten periods of N=3.
    do_reset();
    load(3);
    repeat (30) step();
`ifdef VCO_DIV_PERIOD_CNT_EN
    exp_pc10 = 10;
`else
    exp_pc10 = 0;
`endif
    chk("period_cnt_10", period_cnt, exp_pc10);

    // Reset mid-period of N=8 with a ratio staged.
    do_reset();
    load(8);
    run_until(0, 1);
    load(5);
    chk("pend_before_rst", div_n_rdy, 0);
    do_reset();
    repeat (10) step();
    load(3);
    repeat (9) step();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/vco_fb_divider.md
# vco_fb_divider

Programmable integer feedback divider clocked directly by the VCO output clock. Divides the VCO clock by a runtime-loadable ratio N and produces a divided clock and a one-cycle period tick for the downstream phase/frequency detector that closes the loop back to the VCO control voltage. Ratio changes are accepted through a valid/ready handshake and applied only at a period boundary, so no runt or stretched output period is ever generated.

## Interface
- DIV_W, 8: width of the divide ratio and internal counter
- CNT_W, 16: width of the period counter (only used with the macro below)
- clk  in  1  VCO output clock; all logic on its rising edge
- rst  in  1  asynchronous active-high reset
- div_n  in  DIV_W  requested ratio; 0 = stop request, 1 = illegal, 2..2^DIV_W-1 legal
- div_n_vld  in  1  div_n valid
- div_n_rdy  out  1  block can accept div_n this cycle
- div_clk  out  1  divided clock, registered
- div_tick  out  1  one-cycle pulse in last VCO cycle of each divided period, registered
- running  out  1  high in RUN or PEND
- err  out  1  sticky flag: illegal ratio (1) was received
- period_cnt  out  CNT_W  divided periods completed (macro only)

## Operation
- States: IDLE, RUN, PEND. Reset -> IDLE.
- Reset values: div_clk=0, div_tick=0, running=0, err=0, div_n_rdy=1, period_cnt=0, cnt=0, active ratio=2.
- Transfer occurs on a rising edge with div_n_vld && div_n_rdy. div_n_rdy = 1 in IDLE and RUN, 0 in PEND.
- Ratio 1: accepted, clamped to 2, err set (cleared only by rst).
- IDLE: counter frozen, div_clk=0. Transfer of N>=2 -> RUN, cnt=0, active ratio=N. Transfer of 0 -> stays IDLE.
- RUN: cnt increments 0..N-1 then wraps to 0. div_clk=1 while cnt < ceil(N/2), else 0. div_tick=1 while cnt==N-1.
- RUN transfer when cnt != N-1 -> PEND, ratio staged. Transfer in terminal cycle (cnt==N-1) -> applied at that same wrap edge, stay RUN.
- PEND: counting continues with old ratio; at wrap edge staged ratio becomes active, -> RUN (staged 0 -> IDLE, div_clk=0, cnt=0).
- Stop is only taken at a period boundary; last period always completes.
- rst asserted in any state, mid-period: all state and outputs return to reset values immediately; staged ratio discarded.

## Timing
- Outputs are flops; no combinational path from div_n/div_n_vld to any output except div_n_rdy (pure state decode).
- Start latency: transfer at edge k -> div_clk=1, cnt=0 after edge k; first div_tick in cycle k+N.
- Ratio change latency: new ratio active from first cycle after the current period's wrap edge.
- Divided period is exactly N VCO cycles for every period, including across ratio changes.
- Counter compares at DIV_W bits; N=2^DIV_W-1 max, no overflow of cnt.

## Configuration
- VCO_DIV_PERIOD_CNT_EN defined: period_cnt increments on every wrap edge in RUN/PEND (including the wrap that stops), wraps modulo 2^CNT_W, held in IDLE, reset to 0.
- Not defined: period_cnt port present, tied to 0, no counter logic synthesised.

## Structure
- Shared package vco_pkg: state enum (IDLE, RUN, PEND), DIV_W/CNT_W defaults, constant for min legal ratio (2).
- Natural sub-module: vco_div_counter (modulo-N counter with wrap/terminal outputs and duty decode); FSM and handshake stay in top.

## Test plan
- Reset, load N=4 -> div_clk pattern 1,1,0,0 repeating; div_tick every 4th cycle when cnt==3; running=1.
- N=5 -> div_clk high 3 cycles, low 2; period exactly 5 cycles.
- Running N=4, load N=6 at cnt=1 -> div_n_rdy low until wrap; next period 6 cycles; no period other than 4 or 6.
- Load N=3 exactly in terminal cycle -> applied at that wrap; rdy stays high; next period 3 cycles.
- Load N=1 -> behaves as N=2, err=1 and stays 1; then load 0 -> current period completes, IDLE, div_clk=0.
- Assert rst at cnt=2 of N=8 with pending ratio -> all outputs at reset values immediately; with VCO_DIV_PERIOD_CNT_EN, period_cnt counts 10 after 10 periods of N=3, then 0 after reset.
